// File: rtl/irq_controller_pkg.sv
// Shared constants and FSM encoding for the 8-source interrupt front end.
// Bit 7 is the highest-priority source throughout.
package irq_controller_pkg;
   localparam int NUM_IRQ = 8;
   localparam int VEC_W   = 3;
   localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACKD = 2'd2
   } irq_state_e;
endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser per line plus a third flop for rising-edge detection.
// level_o lags the pin by two edges; rise_o is a one-cycle pulse alongside it.
module irq_sync_edge
   import irq_controller_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] in_i,
   output logic [NUM_IRQ-1:0] level_o,
   output logic [NUM_IRQ-1:0] rise_o
);
   logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;

   // s3 resets low so a line already high at reset release counts as an edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= in_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = s2_q & ~s3_q;
endmodule

// File: rtl/priority_encoder.sv
// Combinational highest-set-bit encoder; idx_o is 0 when nothing is set, so gate with vld_o.
// Zero latency, no flow control.
module priority_encoder
   import irq_controller_pkg::*;
(
   input  logic               en_i,
   input  logic [NUM_IRQ-1:0] req_i,
   output logic [VEC_W-1:0]   idx_o,
   output logic               vld_o
);
   always_comb begin
      idx_o = '0;
      vld_o = 1'b0;
      if (en_i) begin
         // ascending scan: the last hit is the highest set bit
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (req_i[i]) begin
               idx_o = VEC_W'(i);
               vld_o = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/irq_controller.sv
// 8-source interrupt controller: sync, pending latch, mask, nesting filter, req/ack handshake.
// Pin to irq_req is 3 edges; irq_req/irq_vec hold until irq_ack, then one idle gap cycle.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter bit EDGE_TRIG = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_wr,
   input  logic [NUM_IRQ-1:0] mask_data,
   output logic [NUM_IRQ-1:0] mask,
   output logic               irq_req,
   output logic [VEC_W-1:0]   irq_vec,
   input  logic               irq_ack,
   input  logic               eoi,
   output logic [NUM_IRQ-1:0] in_service
);
   irq_state_e         state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] isr_q, isr_d;

   logic [NUM_IRQ-1:0] sync_lvl, sync_rise;
   logic [NUM_IRQ-1:0] above, eligible, ack_oh, eoi_oh;
   logic [VEC_W-1:0]   elig_idx, isr_idx;
   logic               elig_vld, isr_vld, ack_fire;

   irq_sync_edge u_sync (
      .clk     (clk),
      .reset   (reset),
      .in_i    (irq_in),
      .level_o (sync_lvl),
      .rise_o  (sync_rise)
   );

   priority_encoder u_enc_elig (
      .en_i  (1'b1),
      .req_i (eligible),
      .idx_o (elig_idx),
      .vld_o (elig_vld)
   );

   priority_encoder u_enc_isr (
      .en_i  (1'b1),
      .req_i (isr_q),
      .idx_o (isr_idx),
      .vld_o (isr_vld)
   );

   // only sources strictly above the highest in-service one may nest
   always_comb begin
      above = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         above[i] = !isr_vld || (i > int'(isr_idx));
      end
   end

   assign eligible = pending_q & ~mask_q & above;

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      ack_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (elig_vld) begin
               state_d = REQ;
               vec_d   = elig_idx;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_d  = ACKD;
               ack_fire = 1'b1;
            end
         end
         ACKD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ack_oh = ack_fire ? (NUM_IRQ'(1) << vec_q) : '0;
   assign eoi_oh = (eoi && isr_vld) ? (NUM_IRQ'(1) << isr_idx) : '0;

   // a new edge beats an ack-clear of the same bit; eoi acts on the pre-cycle set
   assign pending_d = EDGE_TRIG ? ((pending_q & ~ack_oh) | sync_rise) : sync_lvl;
   assign isr_d     = (isr_q & ~eoi_oh) | ack_oh;
   assign mask_d    = mask_wr ? mask_data : mask_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         pending_q <= '0;
         mask_q    <= MASK_RST;
         isr_q     <= '0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         isr_q     <= isr_d;
      end
   end

   assign irq_req    = (state_q == REQ);
   assign irq_vec    = vec_q;
   assign mask       = mask_q;
   assign in_service = isr_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected vectors queued at stimulus time,
// popped and compared when irq_req is seen.
module tb_irq_controller;
   logic       clk;
   logic       reset;
   logic [7:0] irq_in;
   logic       mask_wr;
   logic [7:0] mask_data;
   logic [7:0] mask;
   logic       irq_req;
   logic [2:0] irq_vec;
   logic       irq_ack;
   logic       eoi;
   logic [7:0] in_service;

   int n_cmp = 0;
   int n_bad = 0;
   logic [2:0] sb[$];

   irq_controller #(.EDGE_TRIG(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .mask_wr    (mask_wr),
      .mask_data  (mask_data),
      .mask       (mask),
      .irq_req    (irq_req),
      .irq_vec    (irq_vec),
      .irq_ack    (irq_ack),
      .eoi        (eoi),
      .in_service (in_service)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input int bit_i);
      irq_in[bit_i] = 1'b1;
      step(2);
      irq_in[bit_i] = 1'b0;
   endtask

   task automatic do_ack(input logic with_eoi = 1'b0);
      irq_ack = 1'b1;
      eoi     = with_eoi;
      step();
      irq_ack = 1'b0;
      eoi     = 1'b0;
   endtask

   task automatic do_eoi();
      eoi = 1'b1;
      step();
      eoi = 1'b0;
   endtask

   task automatic wr_mask(input logic [7:0] v);
      mask_wr   = 1'b1;
      mask_data = v;
      step();
      mask_wr   = 1'b0;
   endtask

   // bounded wait for irq_req, then score the vector against the queue head
   task automatic expect_req(input string tag);
      int n = 0;
      logic [2:0] exp_v;
      while (irq_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_req"}, {7'd0, irq_req}, 8'h01);
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end else begin
         exp_v = sb.pop_front();
         chk({tag, "_vec"}, {5'd0, irq_vec}, {5'd0, exp_v});
      end
   endtask

   initial begin
      reset = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
      irq_ack = 1'b0; eoi = 1'b0;
      step(3);
      chk("rst_req",  {7'd0, irq_req}, 8'h00);
      chk("rst_vec",  {5'd0, irq_vec}, 8'h00);
      chk("rst_mask", mask, 8'hFF);
      chk("rst_isr",  in_service, 8'h00);
      reset = 1'b0;
      step();
      wr_mask(8'h00);
      chk("mask_00", mask, 8'h00);

      // 1: exact latency, pin sampled at edge k -> irq_req after edge k+3
      irq_in[5] = 1'b1;
      sb.push_back(3'd5);
      step(3);
      chk("t1_req_k2", {7'd0, irq_req}, 8'h00);
      step();
      irq_in[5] = 1'b0;
      expect_req("t1");
      do_ack();
      chk("t1_isr", in_service, 8'h20);
      chk("t1_gap", {7'd0, irq_req}, 8'h00);
      do_eoi();
      chk("t1_eoi", in_service, 8'h00);

      // 2: simultaneous 2 and 6; 2 held off by in-service 6 until eoi
      irq_in[2] = 1'b1; irq_in[6] = 1'b1;
      sb.push_back(3'd6);
      step(2);
      irq_in[2] = 1'b0; irq_in[6] = 1'b0;
      expect_req("t2a");
      do_ack();
      chk("t2_isr", in_service, 8'h40);
      step(6);
      chk("t2_blocked", {7'd0, irq_req}, 8'h00);
      sb.push_back(3'd2);
      do_eoi();
      chk("t2_eoi", in_service, 8'h00);
      expect_req("t2b");
      do_ack();
      do_eoi();

      // 3: nesting above in-service 3
      sb.push_back(3'd3);
      pulse(3);
      expect_req("t3a");
      do_ack();
      chk("t3_isr8", in_service, 8'h08);
      sb.push_back(3'd7);
      pulse(7);
      expect_req("t3b");
      do_ack();
      chk("t3_isr88", in_service, 8'h88);
      do_eoi();
      chk("t3_eoi", in_service, 8'h08);
      do_eoi();
      chk("t3_eoi2", in_service, 8'h00);

      // 4: masked edge stays pending until unmasked
      wr_mask(8'hFF);
      pulse(4);
      step(8);
      chk("t4_masked", {7'd0, irq_req}, 8'h00);
      sb.push_back(3'd4);
      wr_mask(8'hEF);
      chk("t4_mask", mask, 8'hEF);
      expect_req("t4");
      do_ack();
      do_eoi();
      wr_mask(8'h00);

      // 5: vector frozen during REQ; gap after ack; ack+eoi in one cycle
      sb.push_back(3'd1);
      pulse(1);
      expect_req("t5a");
      pulse(7);
      step(4);
      chk("t5_hold_req", {7'd0, irq_req}, 8'h01);
      chk("t5_hold_vec", {5'd0, irq_vec}, 8'h01);
      sb.push_back(3'd7);
      do_ack();
      chk("t5_gap", {7'd0, irq_req}, 8'h00);
      chk("t5_isr", in_service, 8'h02);
      expect_req("t5b");
      do_ack(1'b1);
      chk("t5_ack_eoi", in_service, 8'h80);
      do_eoi();
      chk("t5_eoi", in_service, 8'h00);

      // 6: async reset while requesting
      sb.push_back(3'd5);
      pulse(5);
      expect_req("t6a");
      do_ack();
      sb.push_back(3'd6);
      pulse(6);
      expect_req("t6b");
      #2;
      reset = 1'b1;
      #1;
      chk("t6_req",  {7'd0, irq_req}, 8'h00);
      chk("t6_mask", mask, 8'hFF);
      chk("t6_isr",  in_service, 8'h00);
      chk("t6_vec",  {5'd0, irq_vec}, 8'h00);
      step(2);
      reset = 1'b0;
      step();
      wr_mask(8'h00);
      step(8);
      chk("t6_no_pend", {7'd0, irq_req}, 8'h00);
      chk("sb_empty", 8'(sb.size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
